// File: rtl/response_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : response_checker_pkg
//  Description : Shared constants, FSM state type and the MISR step function
//                for the golden-vs-netlist response checker.
//  Revision    : 1.0  initial release
// ============================================================================
package response_checker_pkg;

    // CRC-32 generator polynomial used as MISR feedback taps
    localparam logic [31:0] POLY = 32'h04C11DB7;
    // Signature value at reset and at the start of each run
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One MISR step: shift left, apply polynomial feedback, then inject the folded data.
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] fold);
        logic [31:0] fb;
        fb = sig[31] ? POLY : 32'h0;
        return {sig[30:0], 1'b0} ^ fb ^ fold;
    endfunction

endpackage : response_checker_pkg
`default_nettype wire

// File: rtl/response_checker_misr.sv
`default_nettype none
// ============================================================================
//  Module      : misr32
//  Description : 32-bit multiple-input signature register. The wide response
//                vector is folded into 32 bits by XOR-ing its 32-bit chunks
//                (the last chunk zero-padded at the MSB end) and compressed
//                into the running signature on every enabled cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module misr32
    import response_checker_pkg::*;
#(
    parameter int RSP_W = 658
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [RSP_W-1:0] i_vec,
    output logic [31:0]      o_sig
);

    localparam int c_NCH   = (RSP_W + 31) / 32;
    localparam int c_PAD_W = c_NCH * 32;

    logic [c_PAD_W-1:0] w_pad;
    logic [31:0]        w_fold;
    logic [31:0]        r_sig;

    // Zero-extend the vector to a whole number of chunks and XOR the chunks together
    always_comb begin
        w_pad  = '0;
        w_pad[RSP_W-1:0] = i_vec;
        w_fold = '0;
        for (int k = 0; k < c_NCH; k++) begin
            w_fold = w_fold ^ w_pad[k*32 +: 32];
        end
    end

    // Signature register: seed on reset or run start, compress on each accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, w_fold);
        end
    end

    assign o_sig = r_sig;

endmodule : misr32
`default_nettype wire

// File: rtl/response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : response_checker
//  Description : Compares golden-model and netlist response beats over a run
//                of N_VEC beats, counting mismatches, recording the first
//                failing beat, and building a MISR signature of each stream.
//  Revision    : 1.0  initial release
// ============================================================================
module response_checker
    import response_checker_pkg::*;
#(
    parameter int RSP_W = 658,
    parameter int N_VEC = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_rsp_valid,
    input  logic [RSP_W-1:0] i_rsp_a,
    input  logic [RSP_W-1:0] i_rsp_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [15:0]      o_mismatch_cnt,
    output logic             o_first_fail_vld,
    output logic [15:0]      o_first_fail_idx,
    output logic [31:0]      o_sig_a,
    output logic [31:0]      o_sig_b
);

    localparam logic [15:0] c_LAST = 16'(N_VEC - 1);
    localparam logic [15:0] c_SAT  = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_beat;
    logic [15:0] r_mm_cnt;
    logic        r_ff_vld;
    logic [15:0] r_ff_idx;

    logic        w_run;
    logic        w_launch;
    logic        w_accept;
    logic        w_mismatch;

    assign w_run      = (r_state == ST_RUN);
    // A start outside RUN launches a run; any beat on that same cycle is dropped
    assign w_launch   = !w_run && i_start;
    assign w_accept   = w_run && i_rsp_valid;
    // Reduction-OR of the XOR keeps the compare free of X-propagation semantics
    assign w_mismatch = |(i_rsp_a ^ i_rsp_b);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start launches from IDLE/DONE, final beat closes the run
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (i_rsp_valid && (r_beat == c_LAST)) w_state_nxt = ST_DONE;
            ST_DONE: if (i_start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Beat counter, saturating mismatch counter and first-failure capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat   <= '0;
            r_mm_cnt <= '0;
            r_ff_vld <= 1'b0;
            r_ff_idx <= '0;
        end else if (w_launch) begin
            r_beat   <= '0;
            r_mm_cnt <= '0;
            r_ff_vld <= 1'b0;
            r_ff_idx <= '0;
        end else if (w_accept) begin
            r_beat <= r_beat + 16'd1;
            if (w_mismatch) begin
                if (r_mm_cnt != c_SAT) begin
                    r_mm_cnt <= r_mm_cnt + 16'd1;
                end
                if (!r_ff_vld) begin
                    r_ff_vld <= 1'b1;
                    r_ff_idx <= r_beat;
                end
            end
        end
    end

    misr32 #(.RSP_W(RSP_W)) u_misr_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_launch),
        .i_en   (w_accept),
        .i_vec  (i_rsp_a),
        .o_sig  (o_sig_a)
    );

    misr32 #(.RSP_W(RSP_W)) u_misr_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_launch),
        .i_en   (w_accept),
        .i_vec  (i_rsp_b),
        .o_sig  (o_sig_b)
    );

    assign o_busy           = w_run;
    assign o_done           = (r_state == ST_DONE);
    // Derived only from registered state, so no path from the response inputs
    assign o_pass           = (r_state == ST_DONE) && (r_mm_cnt == 16'd0);
    assign o_mismatch_cnt   = r_mm_cnt;
    assign o_first_fail_vld = r_ff_vld;
    assign o_first_fail_idx = r_ff_idx;

endmodule : response_checker
`default_nettype wire

// File: doc/response_checker.md
RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 Parameter RSP_W, default 658, SHALL set the width of each response vector.
REQ-002 Parameter N_VEC, default 20, SHALL set the number of response beats per run (range 1..65535).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 start  input  1  SHALL be a run-start pulse.
REQ-006 rsp_valid  input  1  SHALL qualify rsp_a/rsp_b as one response beat.
REQ-007 rsp_a  input  RSP_W  SHALL carry the golden-model response.
REQ-008 rsp_b  input  RSP_W  SHALL carry the synthesized-netlist response.
REQ-009 busy  output  1  SHALL be high while a run is in progress.
REQ-010 done  output  1  SHALL be high when a run has completed and results are held.
REQ-011 pass  output  1  SHALL be high when done=1 and mismatch_cnt=0.
REQ-012 mismatch_cnt  output  16  SHALL count mismatching beats.
REQ-013 first_fail_vld / first_fail_idx  output  1/16  SHALL flag and give the beat index of the first mismatch.
REQ-014 sig_a / sig_b  output  32/32  SHALL hold the MISR signatures of rsp_a and rsp_b.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL move to RUN and clear the beat counter, mismatch_cnt and first_fail_vld, and load both signatures with SEED.
REQ-017 In RUN, each cycle with rsp_valid=1 SHALL be one accepted beat; the beat counter SHALL increment by 1.
REQ-018 A beat SHALL mismatch when rsp_a != rsp_b across all RSP_W bits.
REQ-019 On a mismatching beat, mismatch_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-020 On the first mismatching beat of a run, first_fail_vld SHALL set and first_fail_idx SHALL capture the beat index (0-based); later mismatches SHALL NOT change them.
REQ-021 Per accepted beat, each signature SHALL update: fold = XOR of the 32-bit chunks of the vector, zero-padded at the MSB end; sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
REQ-022 The beat with index N_VEC-1 SHALL move the FSM to DONE, so done=1 in the following cycle (latency 1).
REQ-023 In DONE, all results SHALL hold. start=1 SHALL restart exactly as in REQ-016.
REQ-024 start in RUN SHALL be ignored.
REQ-025 rsp_valid in IDLE or DONE SHALL be ignored, and the signatures and counters SHALL NOT change.
REQ-026 If start and rsp_valid are both high in IDLE or DONE, the beat SHALL be ignored; counting begins the next cycle.
REQ-027 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); pass SHALL be registered or derived with no combinational path from rsp inputs.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and clear these outputs to 0: busy, done, pass, mismatch_cnt, first_fail_vld, first_fail_idx. sig_a and sig_b SHALL reset to SEED.
REQ-029 Reset mid-RUN SHALL abandon the run with no partial result retained; rst_n SHALL take priority over start and rsp_valid.

Structure
REQ-030 Package response_checker_pkg SHALL hold POLY=32'h04C11DB7, SEED=32'hFFFFFFFF and the FSM state type.
REQ-031 The fold-and-shift logic SHALL be one sub-module, misr32 (parameter RSP_W), instantiated twice (a and b).
REQ-032 The block SHALL be synthesizable, with no X-sensitive comparison operators.

Verification
REQ-033 Reset check: rst_n low for 2 cycles with start=1 -> busy=0, done=0, mismatch_cnt=0, sig_a=sig_b=32'hFFFFFFFF.
REQ-034 Identical run: N_VEC=20, rsp_a=rsp_b on all beats -> done 1 cycle after beat 19, pass=1, mismatch_cnt=0, sig_a==sig_b, both matching the reference model.
REQ-035 Single mismatch: flip bit 657 of rsp_b on beat 7 only -> mismatch_cnt=1, first_fail_idx=7, pass=0, sig_a!=sig_b.
REQ-036 Gapped and ignored beats: insert rsp_valid=0 gaps; drive rsp_valid in IDLE; assert start mid-RUN -> counts and signatures are unchanged versus the gap-free run.
REQ-037 Reset mid-run: assert rst_n=0 after beat 5, then start a fresh run -> results equal a clean run on the same data.
REQ-038 Saturation: N_VEC=65535 with all beats mismatching -> mismatch_cnt=16'hFFFF and first_fail_idx=0.
